ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 31 +++
 rtl/ex_muldiv.sv | 126 ++++++++++++
 tb/tb_ex_muldiv.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared EX-stage constants for the iterative RV32M multiply/divide unit:
// funct3 op encodings, FSM state encodings and the iteration count.
package ex_muldiv_pkg;

  // RV32M funct3 encodings, kept alongside the ALU_control encodings
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int MD_ITERS = 32;
  localparam int MD_CNT_W = $clog2(MD_ITERS);

  // Magnitude of v when it is to be treated as signed, otherwise v unchanged
  function automatic logic [31:0] md_mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative multiplier/divider: shift-add for multiply,
// subtract-restore for divide, on a 64-bit {hi, lo} working register.
module muldiv_step
  import ex_muldiv_pkg::*;
(
  input  logic        is_div,
  input  logic [63:0] acc_i,
  input  logic [31:0] b_i,
  output logic [63:0] acc_o
);

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [31:0] diff;
  logic        ge;

  always_comb begin
    // multiply: lo holds the remaining multiplier bits, hi accumulates
    sum    = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, b_i} : 33'd0);
    // divide: shift next dividend bit into the partial remainder
    rem_sh = {acc_i[63:32], acc_i[31]};
    ge     = (rem_sh >= {1'b0, b_i});
    // remainder stays below the divisor, so 32-bit modular subtract suffices
    diff   = rem_sh[31:0] - b_i;
    if (is_div)
      acc_o = ge ? {diff, acc_i[30:0], 1'b1} : {rem_sh[31:0], acc_i[30:0], 1'b0};
    else
      acc_o = {sum, acc_i[31:1]};
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: 32 CALC cycles per
// op, with divide-by-zero and signed overflow resolved without iterating.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  logic [1:0]          state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [31:0]         b_q, b_d;
  logic [63:0]         acc_q, acc_d;
  logic [31:0]         result_q, result_d;

  logic [63:0] step_acc;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, res_fin;
  logic        a_signed, b_signed, neg_in, div_zero, div_ovf;

  muldiv_step u_step (
    .is_div (op_q[2]),
    .acc_i  (acc_q),
    .b_i    (b_q),
    .acc_o  (step_acc)
  );

  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    // remainder follows the dividend; everything else follows the sign product
    neg_in   = (op == OP_REM) ? A[31] : ((a_signed & A[31]) ^ (b_signed & B[31]));
    div_zero = op[2] && (B == 32'd0);
    div_ovf  = op[2] && !op[0] && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  end

  always_comb begin
    prod_fix = neg_q ? (64'd0 - step_acc) : step_acc;
    quo_fix  = neg_q ? (32'd0 - step_acc[31:0])  : step_acc[31:0];
    rem_fix  = neg_q ? (32'd0 - step_acc[63:32]) : step_acc[63:32];
    if (op_q[2])
      res_fin = op_q[1] ? rem_fix : quo_fix;
    else
      res_fin = (op_q == OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = op;
          neg_d = neg_in;
          b_d   = md_mag(B, b_signed);
          acc_d = {32'd0, md_mag(A, a_signed)};
          cnt_d = '0;
          if (div_zero) begin
            result_d = op[1] ? A : 32'hFFFF_FFFF;
            state_d  = ST_DONE;
          end else if (div_ovf) begin
            result_d = op[1] ? 32'd0 : 32'h8000_0000;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + MD_CNT_W'(1);
        if (cnt_q == MD_CNT_W'(MD_ITERS - 1)) begin
          result_d = res_fin;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // abort wins over acceptance and completion; the held result survives
    if (flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: arithmetic reference model checked every cycle plus
// directed vectors with hand-computed results and latencies.
module tb_ex_muldiv;

  logic        clk, rst, start, flush;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && ((b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Reference result straight from the RV32M definitions
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'b000: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycle model: m_left = cycles still to go including the done cycle
  initial begin
    bit          m_valid;
    int          m_left;
    logic [31:0] m_res, m_pend;
    m_valid = 0; m_left = 0; m_res = 0; m_pend = 0;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("busy",   {31'd0, busy}, {31'd0, m_left != 0});
        chk("done",   {31'd0, done}, {31'd0, m_left == 1});
        chk("result", result, m_res);
      end
      if (rst) begin
        m_valid = 1; m_left = 0; m_res = 0;
      end else if (m_valid) begin
        if (flush) m_left = 0;
        else if (m_left == 0) begin
          if (start) begin
            m_pend = ref_res(op, A, B);
            if (is_special(op, A, B)) begin m_left = 1; m_res = m_pend; end
            else m_left = 33;
          end
        end else begin
          m_left--;
          if (m_left == 1) m_res = m_pend;
        end
      end
    end
  end

  task automatic wait_done(input int t0, input logic [31:0] exp, input int lat, input string nm);
    bit seen;
    int dc;
    seen = 0; dc = 0;
    for (int k = 0; k < 45 && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1; dc = cyc; end
    end
    chk({nm, " done seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      chk({nm, " latency"}, dc - t0, lat);
      chk({nm, " value"}, result, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string nm);
    int t0;
    t0 = cyc;
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom_range(7, 0)); A = $urandom; B = $urandom;
    wait_done(t0, exp, lat, nm);
  endtask

  initial begin
    int t0, t1;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    @(posedge clk); #1;

    run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MUL 7*-3");
    run_op(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU");
    run_op(3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33, "MULH");
    run_op(3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33, "MULHSU");
    run_op(3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, "DIV -7/2");
    run_op(3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, "REM -7%2");
    run_op(3'b101, 32'd100,        32'd7,         32'd14,        33, "DIVU");
    run_op(3'b111, 32'd100,        32'd7,         32'd2,         33, "REMU");
    run_op(3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  "DIVU by 0");
    run_op(3'b111, 32'd5,          32'd0,         32'd5,         1,  "REMU by 0");
    run_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  "DIV ovf");
    run_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  "REM ovf");
    run_op(3'b110, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1,  "REM by 0");
    run_op(3'b101, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33, "DIVU big");
    run_op(3'b111, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33, "REMU big");
    run_op(3'b100, 32'h8000_0000,  32'd1,         32'h8000_0000, 33, "DIV min/1");
    run_op(3'b011, 32'h8000_0000,  32'd2,         32'd1,         33, "MULHU carry");
    run_op(3'b000, 32'h0001_0000,  32'h0001_0000, 32'd0,         33, "MUL wrap");
    run_op(3'b100, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, "DIV 100/-7");
    run_op(3'b110, 32'd100,        32'hFFFF_FFF9, 32'd2,         33, "REM 100%-7");

    // flush in cycle 10 of a MUL, new op started in cycle 11
    t0 = cyc;
    start = 1'b1; op = 3'b000; A = 32'd3; B = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    start = 1'b1; op = 3'b101; A = 32'd1000; B = 32'd10;
    t1 = cyc;
    chk("flush cycle offset", t1 - t0, 32'd11);
    @(negedge clk);
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush done", {31'd0, done}, 32'd0);
    chk("flush result", result, 32'd2);
    @(posedge clk); #1 start = 1'b0;
    wait_done(t1, 32'd100, 33, "after flush");

    // start pulses in cycles 5 and 20 are ignored
    t0 = cyc;
    start = 1'b1; op = 3'b000; A = 32'd6; B = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1; op = 3'b101; A = 32'd9; B = 32'd0;
    @(posedge clk); #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #1 start = 1'b1; op = 3'b011; A = 32'd1; B = 32'd1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(t0, 32'd42, 33, "ignored starts");

    // reset in cycle 15 of a DIV
    start = 1'b1; op = 3'b100; A = 32'd1000; B = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst result", result, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MUL after rst");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
